jtbubl_pal_ctrl: RTL and testbench

Palette access controller for the single-port 512×8 palette RAM used by the colour mixer. It clears the RAM after reset, then time-slices every pixel period between two video reads and one CPU access. The video reads are the even byte and the odd byte of a 16-bit colour. The block returns the assembled 16-bit colour on `pxl_cen`. It sits between the CPU bus decoder, the tile/object priority logic that supplies `col_addr`, and the palette RAM instance.

---
 rtl/jtbubl_pal_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_jtbubl_pal_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtbubl_pal_ctrl.sv
// Palette RAM access controller: clears the RAM after reset, then splits each
// pixel period into two video byte reads and one CPU access slot.
module jtbubl_pal_ctrl #(
    parameter int CLRW = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pxl_cen,
    input  logic [CLRW-2:0] col_addr,
    input  logic            pal_cs,
    input  logic            cpu_rnw,
    input  logic [CLRW-1:0] cpu_addr,
    input  logic [7:0]      cpu_dout,
    output logic [7:0]      pal_dout,
    output logic            cpu_ok,
    output logic [CLRW-1:0] ram_addr,
    output logic [7:0]      ram_din,
    output logic            ram_we,
    input  logic [7:0]      ram_dout,
    output logic [15:0]     col_out,
    output logic            clr_done
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CLRW-1:0] clr_cnt_q, clr_cnt_d;
    logic [1:0]      ph_q, ph_d;
    logic            pend_q, pend_d;
    logic            served_q, served_d;
    logic            pend_rnw_q;
    logic [CLRW-1:0] pend_addr_q;
    logic [7:0]      pend_data_q;
    logic            cs_q;
    logic            cpu_ok_q;
    logic            rd_q;
    logic [7:0]      pal_dout_q;
    logic [7:0]      even_q, odd_q;
    logic [15:0]     col_out_q;
    logic            clr_done_q;
    logic            grant_s;
    logic            cs_rise_s;

    assign cs_rise_s = pal_cs & ~cs_q;
    // One CPU access per pixel period, only in the slots after both video reads
    assign grant_s   = (state_q == ST_RUN) && pend_q && ph_q[1] && !served_q;

    // Clear sweep and top-level state transitions
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + {{(CLRW-1){1'b0}}, 1'b1};
                if (clr_cnt_q == {CLRW{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = {CLRW{1'b0}};
            end
        endcase
    end

    // Slot counter, served flag and pending-request bookkeeping
    always_comb begin
        ph_d     = ph_q;
        served_d = served_q;
        pend_d   = pend_q;
        if (state_q == ST_RUN) begin
            if (pxl_cen) begin
                ph_d = 2'd0;
            end else if (ph_q != 2'd3) begin
                ph_d = ph_q + 2'd1;
            end else begin
                ph_d = ph_q;
            end
        end else begin
            ph_d = ph_q;
        end
        if (pxl_cen) begin
            served_d = 1'b0;
        end else if (grant_s) begin
            served_d = 1'b1;
        end else begin
            served_d = served_q;
        end
        if (grant_s) begin
            pend_d = 1'b0;
        end else if (cs_rise_s) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
    end

    // RAM port mux: the RAM samples its address at the edge, so this stays combinational
    always_comb begin
        ram_we   = 1'b0;
        ram_din  = 8'h00;
        ram_addr = {col_addr, ph_q[0]};
        if (state_q == ST_CLEAR) begin
            ram_we   = 1'b1;
            ram_addr = clr_cnt_q;
        end else if (grant_s) begin
            ram_we   = ~pend_rnw_q;
            ram_din  = pend_data_q;
            ram_addr = pend_addr_q;
        end else begin
            ram_we   = 1'b0;
        end
    end

    // State, counters and CPU request latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= {CLRW{1'b0}};
            ph_q        <= 2'd3;
            pend_q      <= 1'b0;
            served_q    <= 1'b0;
            pend_rnw_q  <= 1'b1;
            pend_addr_q <= {CLRW{1'b0}};
            pend_data_q <= 8'h00;
            cs_q        <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            ph_q       <= ph_d;
            pend_q     <= pend_d;
            served_q   <= served_d;
            cs_q       <= pal_cs;
            clr_done_q <= (state_d == ST_RUN);
            if (cs_rise_s && !pend_q) begin
                pend_rnw_q  <= cpu_rnw;
                pend_addr_q <= cpu_addr;
                pend_data_q <= cpu_dout;
            end
        end
    end

    // CPU completion, video byte capture and colour output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_ok_q   <= 1'b0;
            rd_q       <= 1'b0;
            pal_dout_q <= 8'h00;
            even_q     <= 8'h00;
            odd_q      <= 8'h00;
            col_out_q  <= 16'h0000;
        end else begin
            cpu_ok_q <= grant_s;
            rd_q     <= grant_s & pend_rnw_q;
            if (rd_q) begin
                pal_dout_q <= ram_dout;
            end
            if (state_q == ST_RUN && ph_q == 2'd1) begin
                even_q <= ram_dout;
            end
            if (state_q == ST_RUN && ph_q == 2'd2) begin
                odd_q <= ram_dout;
            end
            if (pxl_cen) begin
                col_out_q <= (state_q == ST_CLEAR) ? 16'h0000 : {odd_q, even_q};
            end
        end
    end

    // Read data is shown in the same cycle as cpu_ok, then held
    assign pal_dout = rd_q ? ram_dout : pal_dout_q;
    assign cpu_ok   = cpu_ok_q;
    assign col_out  = col_out_q;
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_jtbubl_pal_ctrl.sv
// Self-checking bench for jtbubl_pal_ctrl with a behavioural palette RAM and
// scoreboard queues for CPU accesses and video colours.
module tb_jtbubl_pal_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pxl_cen = 1'b0;
    logic [7:0]  col_addr = 8'h00;
    logic        pal_cs = 1'b0;
    logic        cpu_rnw = 1'b1;
    logic [8:0]  cpu_addr = 9'h000;
    logic [7:0]  cpu_dout = 8'h00;
    logic [7:0]  pal_dout;
    logic        cpu_ok;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [15:0] col_out;
    logic        clr_done;

    jtbubl_pal_ctrl #(.CLRW(9)) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .col_addr(col_addr),
        .pal_cs(pal_cs), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .pal_dout(pal_dout), .cpu_ok(cpu_ok), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_dout(ram_dout), .col_out(col_out), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    // Behavioural RAM with a backdoor write port for preloading
    logic [7:0] mem [0:511];
    logic       bd_we = 1'b0;
    logic [8:0] bd_addr = 9'h000;
    logic [7:0] bd_data = 8'h00;
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    typedef struct { logic rnw; logic [8:0] addr; logic [7:0] data; } req_t;
    req_t        exp_q[$];
    logic [15:0] exp_col[$];
    logic [7:0]  ref_mem [0:511];
    int checks = 0;
    int errors = 0;
    int j_s = 3;
    int we_cnt = 0;
    bit ok_due = 1'b0;

    // Scoreboard monitor: pops CPU expectations as the DUT performs accesses
    always @(negedge clk) begin
        req_t r;
        if (clr_done === 1'b1) begin
            if (ok_due) begin
                checks++;
                if (cpu_ok !== 1'b1) begin
                    errors++;
                    $display("FAIL write_ok: cpu_ok=%b expected 1 the cycle after the write", cpu_ok);
                end
                ok_due = 1'b0;
            end else if (cpu_ok === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].rnw !== 1'b1) begin
                    errors++;
                    $display("FAIL unexpected_ok: cpu_ok=1 with no read outstanding (queue=%0d)", exp_q.size());
                end else begin
                    r = exp_q.pop_front();
                    if (pal_dout !== r.data) begin
                        errors++;
                        $display("FAIL read_data addr=%h: pal_dout=%h expected %h", r.addr, pal_dout, r.data);
                    end
                end
            end
            if (ram_we === 1'b1) begin
                we_cnt++;
                checks++;
                if (j_s < 2) begin
                    errors++;
                    $display("FAIL slot: ram_we=1 in slot %0d, expected only in slot 2 or 3", j_s);
                end
                checks++;
                if (exp_q.size() == 0 || exp_q[0].rnw !== 1'b0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%h data=%h with no write outstanding", ram_addr, ram_din);
                end else begin
                    r = exp_q.pop_front();
                    if (ram_addr !== r.addr || ram_din !== r.data) begin
                        errors++;
                        $display("FAIL write_port: addr=%h data=%h expected addr=%h data=%h", ram_addr, ram_din, r.addr, r.data);
                    end
                    ok_due = 1'b1;
                end
            end
            if (pxl_cen === 1'b1) begin
                checks++;
                if (we_cnt > 1) begin
                    errors++;
                    $display("FAIL one_per_period: %0d writes in one pixel period, expected at most 1", we_cnt);
                end
                we_cnt = 0;
            end
        end
    end

    task automatic bd_write(input logic [8:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bd_we = 1'b1; bd_addr = a; bd_data = d; ref_mem[a] = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; pxl_cen = 1'b0; pal_cs = 1'b0; j_s = 3; we_cnt = 0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_clear();
        int n = 0;
        while (clr_done !== 1'b1 && n < 700) begin @(negedge clk); n++; end
        checks++;
        if (clr_done !== 1'b1) begin
            errors++;
            $display("FAIL clear_timeout: clr_done=%b expected 1 within 700 clk", clr_done);
        end
    endtask

    task automatic cpu_req(input logic rnw, input logic [8:0] a, input logic [7:0] d);
        req_t r;
        int n = 0;
        @(posedge clk); #1;
        r.rnw = rnw; r.addr = a; r.data = rnw ? ref_mem[a] : d;
        if (!rnw) ref_mem[a] = d;
        exp_q.push_back(r);
        pal_cs = 1'b1; cpu_rnw = rnw; cpu_addr = a; cpu_dout = d;
        do begin @(negedge clk); n++; end while (cpu_ok !== 1'b1 && n < 64);
        checks++;
        if (cpu_ok !== 1'b1) begin
            errors++;
            $display("FAIL cpu_timeout addr=%h: no cpu_ok within 64 clk", a);
        end
        @(posedge clk); #1 pal_cs = 1'b0;
    endtask

    task automatic run_pixels(input int n, input int len, input logic [7:0] base);
        logic [7:0] ca = 8'h00;
        logic [15:0] e;
        @(posedge clk); #1;
        pxl_cen = 1'b1; j_s = 3;
        for (int p = 0; p <= n; p++) begin
            for (int j = 0; j < ((p == n) ? 1 : len); j++) begin
                @(posedge clk); #1;
                j_s = (j > 3) ? 3 : j;
                pxl_cen = (p < n) && (j == len - 1);
                if (j == 0) begin
                    ca = (base + 8'(p * 13)) & 8'h7F;
                    col_addr = ca;
                end
                @(negedge clk);
                if (j == 0) begin
                    if (p > 0) begin
                        e = exp_col.pop_front();
                        checks++;
                        if (col_out !== e) begin
                            errors++;
                            $display("FAIL video pixel %0d: col_out=%h expected %h", p - 1, col_out, e);
                        end
                    end
                    if (p < n) exp_col.push_back({mem[{ca, 1'b1}], mem[{ca, 1'b0}]});
                end
            end
        end
        pxl_cen = 1'b0;
        j_s = 3;
    endtask

    task automatic test_reset();
        int bad = 0;
        int nz = 0;
        rst = 1'b1;
        for (int i = 0; i < 512; i++) begin
            bd_we = 1'b1; bd_addr = 9'(i); bd_data = 8'hFF;
            @(posedge clk); #1;
        end
        bd_we = 1'b0;
        @(negedge clk);
        checks += 6;
        if (col_out !== 16'h0000) begin errors++; $display("FAIL rst_col_out: %h expected 0000", col_out); end
        if (pal_dout !== 8'h00) begin errors++; $display("FAIL rst_pal_dout: %h expected 00", pal_dout); end
        if (cpu_ok !== 1'b0) begin errors++; $display("FAIL rst_cpu_ok: %b expected 0", cpu_ok); end
        if (clr_done !== 1'b0) begin errors++; $display("FAIL rst_clr_done: %b expected 0", clr_done); end
        if (ram_we !== 1'b1) begin errors++; $display("FAIL rst_ram_we: %b expected 1", ram_we); end
        if (ram_addr !== 9'h000) begin errors++; $display("FAIL rst_ram_addr: %h expected 000", ram_addr); end
        do_reset();
        for (int c = 0; c < 512; c++) begin
            pxl_cen = (c % 4 == 3);
            @(negedge clk);
            if (ram_we !== 1'b1 || ram_addr !== 9'(c) || ram_din !== 8'h00 ||
                clr_done !== 1'b0 || col_out !== 16'h0000) bad++;
            @(posedge clk); #1;
        end
        pxl_cen = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL sweep: %0d bad cycles, expected 0", bad); end
        @(negedge clk);
        checks++;
        if (clr_done !== 1'b1 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL clr_done_512: clr_done=%b ram_we=%b expected 1 and 0", clr_done, ram_we);
        end
        for (int i = 0; i < 512; i++) if (mem[i] !== 8'h00) nz++;
        checks++;
        if (nz != 0) begin errors++; $display("FAIL cleared_ram: %0d nonzero bytes, expected 0", nz); end
    endtask

    task automatic test_video();
        bd_write(9'h02A, 8'h34);
        bd_write(9'h02B, 8'h12);
        for (int i = 0; i < 128; i++)
            if (i != 8'h2A && i != 8'h2B) bd_write(9'(i), 8'(i * 37 + 5));
        run_pixels(3, 4, 8'h15);
        run_pixels(6, 5, 8'h40);
    endtask

    task automatic test_cpu_write_read();
        fork
            run_pixels(10, 4, 8'h10);
            begin
                cpu_req(1'b0, 9'h101, 8'hA5);
                cpu_req(1'b1, 9'h101, 8'h00);
            end
        join
        checks++;
        if (mem[9'h101] !== 8'hA5) begin errors++; $display("FAIL ram_101: %h expected a5", mem[9'h101]); end
        checks++;
        if (pal_dout !== 8'hA5) begin errors++; $display("FAIL pal_dout_hold: %h expected a5", pal_dout); end
    endtask

    task automatic test_slot_protection();
        fork
            run_pixels(20, 8, 8'h05);
            for (int k = 0; k < 8; k++) cpu_req(1'b0, 9'(9'h100 + k * 17), 8'($urandom_range(255)));
        join
        fork
            run_pixels(12, 8, 8'h33);
            for (int k = 0; k < 4; k++) cpu_req(1'b1, 9'(9'h100 + k * 34), 8'h00);
        join
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drain: %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_clear_request();
        int early = 0;
        int oks = 0;
        do_reset();
        repeat (10) begin @(posedge clk); #1; end
        begin
            req_t r;
            r.rnw = 1'b0; r.addr = 9'h000; r.data = 8'h77;
            exp_q.push_back(r);
            ref_mem[0] = 8'h77;
        end
        pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 9'h000; cpu_dout = 8'h77;
        for (int n = 0; n < 700; n++) begin
            @(negedge clk);
            if (clr_done === 1'b1) break;
            if (cpu_ok !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin errors++; $display("FAIL ok_in_clear: %0d pulses, expected 0", early); end
        checks++;
        if (clr_done !== 1'b1) begin errors++; $display("FAIL clear_req_done: clr_done=%b expected 1", clr_done); end
        for (int n = 0; n < 20; n++) begin
            if (cpu_ok === 1'b1) oks++;
            @(negedge clk);
        end
        pal_cs = 1'b0;
        checks++;
        if (oks != 1) begin errors++; $display("FAIL clear_req_ok: %0d pulses, expected 1", oks); end
        checks++;
        if (mem[0] !== 8'h77) begin errors++; $display("FAIL clear_req_ram: %h expected 77", mem[0]); end
    endtask

    task automatic test_mid_clear_reset();
        int n = 0;
        int bad = 0;
        do_reset();
        repeat (300) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (ram_addr !== 9'd300) begin errors++; $display("FAIL sweep_300: ram_addr=%0d expected 300", ram_addr); end
        rst = 1'b1;
        #1;
        checks++;
        if (ram_addr !== 9'h000 || ram_we !== 1'b1 || clr_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: addr=%h we=%b done=%b expected 000 1 0", ram_addr, ram_we, clr_done);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        while (n < 700) begin
            @(negedge clk);
            if (clr_done === 1'b1) break;
            if (ram_addr !== 9'(n)) bad++;
            n++;
        end
        checks++;
        if (n != 512 || bad != 0) begin
            errors++;
            $display("FAIL restart_len: %0d cycles (%0d bad addrs), expected 512 (0)", n, bad);
        end
    endtask

    initial begin
        test_reset();
        test_video();
        test_cpu_write_read();
        test_slot_protection();
        test_clear_request();
        test_mid_clear_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
